// File: rtl/ps2_scancode_controller.sv
// ps2_scancode_controller
//   Sequences the PS/2 receive path. It gates the receiver through rx_enable and
//   decodes set-2 prefix bytes (E0 extended, F0 break, E1 pause) into whole key
//   events. Those events are queued in a first-word-fall-through FIFO.
//   Optional build macro: PS2_TYPEMATIC_FILTER_EN. When it is defined, repeated
//   make codes for a key that is still held are dropped. The default build passes
//   every make through.
module ps2_scancode_controller #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       rx_enable,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   input  logic       rd_en,
   output logic       fifo_full,
   output logic       overflow,
   input  logic       clr_overflow
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TO_LAST_C = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_SKIP    = 3'd4
   } state_t;

   // Bytes that open or continue a multi-byte sequence.
   function automatic logic is_prefix(input logic [7:0] b);
      return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
   endfunction

   // Controller responses, BAT and error codes that never become key events.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
             (b == 8'h00) || (b == 8'hFF);
   endfunction

   state_t          state_r, state_nxt_s;
   logic [2:0]      skip_cnt_r, skip_nxt_s;
   logic [TW-1:0]   to_cnt_r;
   logic            timeout_s;
   logic            push_s, push_ext_s, push_brk_s;
   logic            fifo_push_s;

   logic [7:0]      code_mem_r [FIFO_DEPTH];
   logic            ext_mem_r  [FIFO_DEPTH];
   logic            brk_mem_r  [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            full_s, pop_s, wr_ok_s, drop_s;
   logic            overflow_r, rx_enable_r;

   // Abandon a stalled sequence once the idle budget inside it runs out.
   assign timeout_s = (state_r != ST_IDLE) && !rx_done_tick && (to_cnt_r == TO_LAST_C);

   // State register together with the pause-sequence skip counter.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r    <= ST_IDLE;
         skip_cnt_r <= 3'd0;
      end else begin
         state_r    <= state_nxt_s;
         skip_cnt_r <= skip_nxt_s;
      end
   end

   // Inter-byte idle counter. It runs only inside a sequence.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         to_cnt_r <= '0;
      end else if (rx_done_tick || (state_r == ST_IDLE) || timeout_s) begin
         to_cnt_r <= '0;
      end else begin
         to_cnt_r <= to_cnt_r + TW'(1);
      end
   end

   // Next-state decode. The FSM advances only on a received byte or on a timeout.
   always_comb begin
      state_nxt_s = state_r;
      skip_nxt_s  = skip_cnt_r;
      if (timeout_s) begin
         state_nxt_s = ST_IDLE;
      end else if (rx_done_tick) begin
         case (state_r)
            ST_IDLE: begin
               case (rx_data)
                  8'hE0:   state_nxt_s = ST_EXT;
                  8'hF0:   state_nxt_s = ST_BRK;
                  8'hE1: begin
                     state_nxt_s = ST_SKIP;
                     skip_nxt_s  = 3'd7;
                  end
                  default: state_nxt_s = ST_IDLE;
               endcase
            end
            ST_EXT: begin
               if (rx_data == 8'hF0) begin
                  state_nxt_s = ST_EXT_BRK;
               end else if (rx_data == 8'hE0) begin
                  state_nxt_s = ST_EXT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_SKIP: begin
               skip_nxt_s = skip_cnt_r - 3'd1;
               if (skip_cnt_r == 3'd1) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_SKIP;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Output decode. Decide whether this byte completes a key event, and which flags it carries.
   always_comb begin
      push_s     = 1'b0;
      push_ext_s = 1'b0;
      push_brk_s = 1'b0;
      if (rx_done_tick) begin
         case (state_r)
            ST_IDLE:    push_s = !is_prefix(rx_data) && !is_ignored(rx_data);
            ST_EXT: begin
               push_s     = (rx_data != 8'hF0) && (rx_data != 8'hE0);
               push_ext_s = 1'b1;
            end
            ST_BRK: begin
               push_s     = !is_prefix(rx_data);
               push_brk_s = 1'b1;
            end
            ST_EXT_BRK: begin
               push_s     = !is_prefix(rx_data);
               push_ext_s = 1'b1;
               push_brk_s = 1'b1;
            end
            default:    push_s = 1'b0;
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       held_r, last_ext_r, match_s;
   logic [7:0] last_code_r;

   assign match_s     = (last_ext_r == push_ext_s) && (last_code_r == rx_data);
   assign fifo_push_s = push_s && !(!push_brk_s && held_r && match_s);

   // Remember the last make so that typematic repeats can be recognised and dropped.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         held_r      <= 1'b0;
         last_ext_r  <= 1'b0;
         last_code_r <= 8'h00;
      end else if (push_s && !push_brk_s && !(held_r && match_s)) begin
         held_r      <= 1'b1;
         last_ext_r  <= push_ext_s;
         last_code_r <= rx_data;
      end else if (push_s && push_brk_s && held_r && match_s) begin
         held_r      <= 1'b0;
      end
   end
`else
   assign fifo_push_s = push_s;
`endif

   assign full_s  = (count_r == DEPTH_C);
   assign pop_s   = rd_en && (count_r != '0);
   assign wr_ok_s = fifo_push_s && (!full_s || pop_s);
   assign drop_s  = fifo_push_s && full_s && !pop_s;

   // Event storage. Reset clears it so that the head reads as zero.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            code_mem_r[i] <= 8'h00;
            ext_mem_r[i]  <= 1'b0;
            brk_mem_r[i]  <= 1'b0;
         end
      end else if (wr_ok_s) begin
         code_mem_r[wr_ptr_r] <= rx_data;
         ext_mem_r[wr_ptr_r]  <= push_ext_s;
         brk_mem_r[wr_ptr_r]  <= push_brk_s;
      end
   end

   // Pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_s)   rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({wr_ok_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky overflow flag and receiver gating. A drop wins over a clear in the same cycle.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         overflow_r  <= 1'b0;
         rx_enable_r <= 1'b0;
      end else begin
         rx_enable_r <= !full_s;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clr_overflow) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign rx_enable = rx_enable_r;
   assign overflow  = overflow_r;
   assign fifo_full = full_s;
   assign ev_valid  = (count_r != '0);
   assign ev_code   = code_mem_r[rd_ptr_r];
   assign ev_ext    = ext_mem_r[rd_ptr_r];
   assign ev_break  = brk_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_ps2_scancode_controller.sv
// tb_ps2_scancode_controller
//   Randomised and directed bench. It uses a prefix-flag reference model of the
//   key-event stream and a queue that stands in for the event FIFO.
module tb_ps2_scancode_controller;

   localparam int DEPTH = 8;
   localparam int TO    = 40;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rd_en = 1'b0;
   logic       clr_overflow = 1'b0;
   logic       rx_enable, ev_valid, ev_ext, ev_break, fifo_full, overflow;
   logic [7:0] ev_code;

   ps2_scancode_controller #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .rx_enable(rx_enable), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
      .ev_break(ev_break), .rd_en(rd_en), .fifo_full(fifo_full), .overflow(overflow),
      .clr_overflow(clr_overflow)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   // Reference model state. Queue entries are {ext, brk, code}.
   logic [9:0] exp_q[$];
   bit         exp_ovf;
   bit         m_ext, m_brk;
   int         m_skip;
   bit         f_held, f_ext;
   logic [7:0] f_code;

   function automatic bit special(input logic [7:0] b);
      return b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'h00 || b == 8'hFF;
   endfunction

   task automatic model_clear_seq();
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
   endtask

   task automatic model_emit(input bit ext, input bit brk, input logic [7:0] code);
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!brk) begin
         if (f_held && f_ext == ext && f_code == code) return;
         f_held = 1'b1; f_ext = ext; f_code = code;
      end else if (f_held && f_ext == ext && f_code == code) begin
         f_held = 1'b0;
      end
`endif
      if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back({ext, brk, code});
   endtask

   task automatic model_byte(input logic [7:0] b);
      bit pre;
      pre = (b == 8'hE0 || b == 8'hE1 || b == 8'hF0);
      if (m_skip > 0) begin
         m_skip--;
      end else if (m_brk) begin
         if (!pre) model_emit(m_ext, 1'b1, b);
         model_clear_seq();
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1'b1;
         else if (b != 8'hE0) begin
            model_emit(1'b1, 1'b0, b);
            model_clear_seq();
         end
      end else begin
         if (b == 8'hE0) m_ext = 1'b1;
         else if (b == 8'hF0) m_brk = 1'b1;
         else if (b == 8'hE1) m_skip = 7;
         else if (!special(b)) model_emit(1'b0, 1'b0, b);
      end
   endtask

   task automatic apply_reset();
      @(negedge Clock);
      Reset_n = 1'b0; rx_done_tick = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
      exp_q.delete(); exp_ovf = 1'b0; model_clear_seq();
      f_held = 1'b0; f_ext = 1'b0; f_code = 8'h00;
      repeat (2) @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge Clock);
      rx_data = b; rx_done_tick = 1'b1;
      model_byte(b);
      @(negedge Clock);
      rx_done_tick = 1'b0;
   endtask

   // Pop every expected event, comparing each head, then confirm the FIFO is empty.
   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         total++;
         if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, exp_q[0]})
            begin bad++; $display("FAIL %s_head got=%h want=%h", tag,
               {ev_valid, ev_ext, ev_break, ev_code}, {1'b1, exp_q[0]}); end
         void'(exp_q.pop_front());
         rd_en = 1'b1;
         @(negedge Clock);
         rd_en = 1'b0;
      end
      total++;
      if (ev_valid !== 1'b0) begin bad++; $display("FAIL %s_empty got=%b want=0", tag, ev_valid); end
   endtask

   task automatic test_reset();
      @(negedge Clock);
      Reset_n = 1'b0;
      @(negedge Clock);
      total++;
      if ({rx_enable, ev_valid, ev_code, ev_ext, ev_break, overflow, fifo_full} !== 14'h0)
         begin bad++; $display("FAIL reset_outputs got=%h want=0",
            {rx_enable, ev_valid, ev_code, ev_ext, ev_break, overflow, fifo_full}); end
      apply_reset();
      @(negedge Clock);
      total++;
      if (rx_enable !== 1'b1) begin bad++; $display("FAIL reset_rx_enable got=%b want=1", rx_enable); end
   endtask

   task automatic test_single();
      @(negedge Clock);
      rx_data = 8'h1C; rx_done_tick = 1'b1; model_byte(8'h1C);
      total++;
      if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", ev_valid); end
      @(negedge Clock);
      rx_done_tick = 1'b0;
      total++;
      if (ev_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b want=1", ev_valid); end
      drain("single");
   endtask

   task automatic test_prefixes();
      logic [7:0] seq [7] = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
      for (int i = 0; i < 7; i++) send_byte(seq[i]);
      drain("prefix");
   endtask

   task automatic test_pause();
      logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send_byte(seq[i]);
      total++;
      if (ev_valid !== 1'b0) begin bad++; $display("FAIL pause_none got=%b want=0", ev_valid); end
      send_byte(8'h1C);
      drain("pause");
   endtask

   task automatic test_timeout();
      apply_reset();
      send_byte(8'hE0);
      repeat (TO + 5) @(negedge Clock);
      model_clear_seq();
      send_byte(8'h1C);
      send_byte(8'hAA);
      send_byte(8'hFA);
      drain("timeout");
      send_byte(8'hF0);
      apply_reset();
      send_byte(8'h1C);
      drain("midreset");
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i));
      @(negedge Clock);
      total++;
      if ({fifo_full, rx_enable, overflow} !== {1'b1, 1'b0, exp_ovf})
         begin bad++; $display("FAIL ovf_flags got=%b want=%b", {fifo_full, rx_enable, overflow},
            {1'b1, 1'b0, exp_ovf}); end
      clr_overflow = 1'b1;
      @(negedge Clock);
      clr_overflow = 1'b0;
      total++;
      if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
      // drop and clear together: the set must win
      rx_data = 8'h20; rx_done_tick = 1'b1; clr_overflow = 1'b1; model_byte(8'h20);
      @(negedge Clock);
      rx_done_tick = 1'b0; clr_overflow = 1'b0;
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_setwins got=%b want=1", overflow); end
      // push and pop in the same cycle while full
      total++;
      if ({ev_ext, ev_break, ev_code} !== exp_q[0])
         begin bad++; $display("FAIL pushpop_head got=%h want=%h", {ev_ext, ev_break, ev_code}, exp_q[0]); end
      void'(exp_q.pop_front());
      rx_data = 8'h21; rx_done_tick = 1'b1; rd_en = 1'b1; model_byte(8'h21);
      @(negedge Clock);
      rx_done_tick = 1'b0; rd_en = 1'b0;
      total++;
      if (fifo_full !== 1'b1) begin bad++; $display("FAIL pushpop_full got=%b want=1", fifo_full); end
      drain("ovf");
      @(negedge Clock);
      total++;
      if (rx_enable !== 1'b1) begin bad++; $display("FAIL ovf_rxen got=%b want=1", rx_enable); end
   endtask

   task automatic test_filter();
      logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
      apply_reset();
      for (int i = 0; i < 6; i++) send_byte(seq[i]);
      drain("filter");
   endtask

   task automatic test_random();
      logic [7:0] b;
      int r;
      apply_reset();
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) begin
            total++;
            if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, exp_q[0]})
               begin bad++; $display("FAIL rand_head it=%0d got=%h want=%h", it,
                  {ev_valid, ev_ext, ev_break, ev_code}, {1'b1, exp_q[0]}); end
            void'(exp_q.pop_front());
            rd_en = 1'b1;
            @(negedge Clock);
            rd_en = 1'b0;
         end
         r = $urandom_range(0, 11);
         case (r)
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            4:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hAA;
            5:       b = 8'hFA;
            6, 7:    b = 8'h1C;
            8:       b = 8'h75;
            default: b = 8'($urandom);
         endcase
         send_byte(b);
      end
      total++;
      if (overflow !== exp_ovf) begin bad++; $display("FAIL rand_ovf got=%b want=%b", overflow, exp_ovf); end
      // finish any open sequence deterministically before draining
      repeat (TO + 5) @(negedge Clock);
      model_clear_seq();
      drain("rand");
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_prefixes();
      test_pause();
      test_timeout();
      test_overflow();
      test_filter();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
